// File: rtl/ahb_lite_pkg.sv
// Shared constants, FSM state type and command legality check for the
// single-transfer AHB-Lite initiator.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] HRESP_ERR   = 2'd1;
    localparam logic [1:0] ALIGN_ERR   = 2'd2;
    localparam logic [1:0] TIMEOUT_ERR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_e;

    // Legal sizes are byte/half/word, each naturally aligned.
    function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr_lo[0];
            HSIZE_WORD: ok = (addr_lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_timeout_cnt.sv
// Data-phase stall counter; flags the stalled cycle that brings the count up
// to TIMEOUT. TIMEOUT = 0 disables it entirely.
module ahb_timeout_cnt #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TERM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (TIMEOUT != 0)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (TIMEOUT != 0) && en_i && (cnt_q == CW'(TERM));

endmodule

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite initiator: one valid/ready command in, one NONSEQ
// transfer on the bus, one response pulse out.
module ahb_lite_master
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic              HWRITE,
    output logic [31:0]       HWDATA,
    input  logic              HREADY,
    input  logic [31:0]       HRDATA,
    input  logic              HRESP
);

    state_e              state_q;
    state_e              state_d;
    logic                cmd_ready_q;
    logic [ADDR_W-1:0]   haddr_q;
    logic [2:0]          hsize_q;
    logic                hwrite_q;
    logic [31:0]         hwdata_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic [1:0]          err_q;
    logic                handshake;
    logic                legal;
    logic                cnt_clr;
    logic                cnt_en;
    logic                timeout_hit;

    assign handshake = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
    assign legal     = cmd_legal(cmd_size, cmd_addr[1:0]);
    assign cnt_clr   = (state_q == ST_ADDR) && HREADY;
    assign cnt_en    = (state_q == ST_DATA) && !HREADY;

    ahb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i (HCLK),
        .rst_i (HRESET),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (timeout_hit)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (handshake) state_d = legal ? ST_ADDR : ST_RESP;
            ST_ADDR: if (HREADY) state_d = ST_DATA;
            ST_DATA: if (HREADY || timeout_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        HTRANS    = HTRANS_IDLE;
        rsp_valid = 1'b0;
        case (state_q)
            ST_ADDR: HTRANS    = HTRANS_NONSEQ;
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Bus controls only change on an accepted legal command, so they hold
    // their last value outside the address phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cmd_ready_q <= 1'b0;
            haddr_q     <= '0;
            hsize_q     <= HSIZE_BYTE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= RSP_OK;
        end else begin
            cmd_ready_q <= (state_d == ST_IDLE);
            if (handshake) begin
                wdata_q <= cmd_wdata;
                if (legal) begin
                    haddr_q  <= cmd_addr;
                    hsize_q  <= cmd_size;
                    hwrite_q <= cmd_write;
                end else begin
                    rdata_q <= '0;
                    err_q   <= ALIGN_ERR;
                end
            end
            if (cnt_clr) begin
                hwdata_q <= hwrite_q ? wdata_q : 32'h0;
            end
            if (state_q == ST_DATA) begin
                if (HREADY) begin
                    err_q   <= HRESP ? HRESP_ERR : RSP_OK;
                    rdata_q <= (!HRESP && !hwrite_q) ? HRDATA : 32'h0;
                end else if (timeout_hit) begin
                    err_q   <= TIMEOUT_ERR;
                    rdata_q <= '0;
                end
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign HADDR     = haddr_q;
    assign HSIZE     = hsize_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

Single-transfer AHB-Lite initiator that turns a simple valid/ready command port into AHB-Lite NONSEQ transfers and returns one response per command. It sits between on-chip control logic (UART command decoder, sequencers) and the AHB-Lite interconnect whose slaves respond with HREADYOUT, HRDATA and HRESP. It handles wait states and error responses, rejects misaligned commands locally, and guards against a hung slave with a data-phase timeout.

## Interface
- ADDR_W, 32: HADDR and cmd_addr width (16..32).
- TIMEOUT, 1024: data-phase cycles before abort; 0 disables the timeout.
- HCLK  in  1: bus clock. All logic is on its rising edge.
- HRESET  in  1: reset. Synchronous and active-high.
- cmd_valid  in  1: command present.
- cmd_ready  out  1: command accepted on the cycle valid && ready.
- cmd_write  in  1: 1 = write, 0 = read.
- cmd_addr  in  ADDR_W: byte address.
- cmd_size  in  3: HSIZE encoding; only 0, 1 or 2 are legal.
- cmd_wdata  in  32: write data, already lane-aligned by the caller.
- rsp_valid  out  1: one-cycle pulse per accepted command.
- rsp_rdata  out  32: read data. Zero for writes and errors.
- rsp_err  out  2: 0 OK, 1 HRESP error, 2 misaligned or illegal size, 3 timeout.
- HADDR  out  ADDR_W; HTRANS  out  2; HSIZE  out  3; HWRITE  out  1; HWDATA  out  32: AHB-Lite master outputs.
- HREADY  in  1: transfer phase done (interconnect-muxed HREADYOUT).
- HRDATA  in  32; HRESP  in  1: read data and response.

## Operation
- FSM states are IDLE, ADDR, DATA, RESP.
- **IDLE:**
  - cmd_ready = 1 and HTRANS = IDLE (00).
  - On handshake, latch write, addr, size and wdata.
  - If size > 2 or the address is not size-aligned (size 1 needs addr[0]=0; size 2 needs addr[1:0]=0): go to RESP with rsp_err = 2. No bus activity.
  - Otherwise go to ADDR.
- **ADDR:**
  - Drive HTRANS = NONSEQ (10), HADDR, HSIZE and HWRITE from the latch.
  - Hold while HREADY = 0, because the previous data phase is still stalled.
  - On HREADY = 1, go to DATA.
- **DATA:**
  - HTRANS = IDLE. HWDATA = latched wdata for writes and 0 for reads.
  - The timeout counter clears on DATA entry and increments each cycle with HREADY = 0.
  - HREADY = 1 and HRESP = 0: capture HRDATA if reading, err = 0, go to RESP.
  - HREADY = 1 and HRESP = 1: err = 1, rdata = 0, go to RESP. This covers both the two-cycle standard error and single-cycle error slaves.
  - HRESP = 1 with HREADY = 0 (first error cycle): stay, and keep HTRANS = IDLE.
  - Counter reaches TIMEOUT (TIMEOUT != 0): err = 3, go to RESP. The bus is left as-is; upstream is responsible for recovery.
- **RESP:** rsp_valid = 1 for exactly one cycle, then go to IDLE. There is no response backpressure.
- HADDR, HSIZE and HWRITE hold their last values outside ADDR. HTRANS is NONSEQ only in ADDR.

## Timing
- Values on HRESET: state IDLE, HTRANS = 00, HADDR = 0, HSIZE = 0, HWRITE = 0, HWDATA = 0, cmd_ready = 0 during reset, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0.
- HRESET mid-transfer drops the transfer immediately and no response is issued.
- Minimum latency is 3 cycles from handshake to rsp_valid: handshake in cycle 0, ADDR in cycle 1, DATA in cycle 2, rsp_valid in cycle 3.
- Each wait state (HREADY = 0 in ADDR or DATA) adds one cycle.
- A misaligned command gives rsp_valid in cycle 1.
- Throughput is one command per 4 cycles at best; the next cmd_ready is in the cycle after RESP.
- All outputs are registered or decoded from state only. No input-to-output combinational path exists.

## Structure
- Shared package ahb_lite_pkg holds:
  - HTRANS_IDLE / BUSY / NONSEQ / SEQ
  - HSIZE_BYTE / HALF / WORD
  - RSP_OK / HRESP_ERR / ALIGN_ERR / TIMEOUT_ERR
  - the FSM state enum
- One sub-module: ahb_timeout_cnt (clear, enable, terminal count at TIMEOUT, disabled when TIMEOUT = 0).

## Test plan
- **Zero-wait write:** write 0x0000_0010, size 2, data 0xDEADBEEF, HREADY tied 1. Expect NONSEQ for 1 cycle with HWRITE = 1, then HWDATA = 0xDEADBEEF, and rsp_valid in cycle 3 with err = 0.
- **Wait-state read:** read 0x0004 with HREADY low for 3 DATA cycles and HRDATA = 0x1234_5678. Expect rsp_valid in cycle 6, rdata = 0x12345678, err = 0.
- **Error responses:**
  - An always-error slave (HRESP = 1, HREADY = 1) gives err = 1 and rdata = 0.
  - A standard two-cycle error (HRESP = 1 with HREADY = 0, then HRESP = 1 with HREADY = 1) gives err = 1 one cycle later.
- **Misalignment:**
  - size 2 at 0x0002 gives err = 2 in cycle 1 and HTRANS never leaves IDLE.
  - size 3 gives err = 2.
- **Timeout:** TIMEOUT = 8, HREADY held 0 in DATA. Expect err = 3 after 8 stalled cycles, then IDLE and cmd_ready = 1.
- **Reset mid-transfer:** assert HRESET in DATA. Next cycle all outputs are at reset values, there is no rsp_valid, and a following write completes normally.
